fir_job_sequencer: RTL



---
 rtl/fir_job_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fir_job_sequencer.sv
// fir_job_sequencer: host-side initiator for one fir_pipelined engine.
// It loads the input samples into the shared RAM, pulses fir_start, waits for
// a rising edge on fir_done, and then drains the results onto a stream with
// backpressure.
// Optional macro FIR_TIMEOUT_EN adds a watchdog on the WAIT state.
// When the watchdog expires, err is set and the drain is skipped.
module fir_job_sequencer #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] cfg_in_addr,
    input  logic [ADDR_W-1:0] cfg_out_addr,
    input  logic [ADDR_W-1:0] cfg_count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              fir_start,
    output logic [ADDR_W-1:0] fir_input_addr,
    output logic [ADDR_W-1:0] fir_output_addr,
    output logic [ADDR_W-1:0] fir_sample_count,
    input  logic              fir_done,
    output logic              busy,
    output logic              job_done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RD, CAP, OUT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   in_addr_q, in_addr_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_last_q, m_last_d;
    logic                fir_start_q, fir_start_d;
    logic                job_done_q, job_done_d;
    logic                err_q, err_d;
    logic                fir_done_q;
    logic                done_edge;
    logic                last_idx;
`ifdef FIR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0]       wdog_q, wdog_d;
`endif

    assign done_edge = fir_done & ~fir_done_q;
    assign last_idx  = (idx_q == count_q - ADDR_W'(1));

    // Next-state and registered-output computation for the job FSM
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_addr_d   = in_addr_q;
        out_addr_d  = out_addr_q;
        count_d     = count_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        fir_start_d = 1'b0;
        job_done_d  = 1'b0;
        err_d       = err_q;
`ifdef FIR_TIMEOUT_EN
        wdog_d      = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                // job_done is registered, so it is high during the first
                // IDLE cycle. A go in that cycle coincides with job_done and
                // is deferred by one cycle.
                if (go && !job_done_q) begin
                    if (cfg_count != '0) begin
                        in_addr_d  = cfg_in_addr;
                        out_addr_d = cfg_out_addr;
                        count_d    = cfg_count;
                        err_d      = 1'b0;
                        idx_d      = '0;
                        state_d    = LOAD;
                    end else begin
                        err_d      = 1'b1;
                        job_done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (s_valid) begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (last_idx) begin
                        state_d     = START;
                        fir_start_d = 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
`ifdef FIR_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (done_edge) begin
                    idx_d   = '0;
                    state_d = RD;
                end
`ifdef FIR_TIMEOUT_EN
                else if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d      = 1'b1;
                    job_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
`endif
            end
            RD: state_d = CAP;
            CAP: begin
                m_data_d  = mem_dout;
                m_valid_d = 1'b1;
                m_last_d  = last_idx;
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        state_d    = IDLE;
                        job_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            in_addr_q   <= '0;
            out_addr_q  <= '0;
            count_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            fir_start_q <= 1'b0;
            job_done_q  <= 1'b0;
            err_q       <= 1'b0;
            fir_done_q  <= 1'b0;
`ifdef FIR_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_addr_q   <= in_addr_d;
            out_addr_q  <= out_addr_d;
            count_q     <= count_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            fir_start_q <= fir_start_d;
            job_done_q  <= job_done_d;
            err_q       <= err_d;
            fir_done_q  <= fir_done;
`ifdef FIR_TIMEOUT_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    // RAM port decode. The port is driven only in LOAD and RD, and is left
    // idle elsewhere so that the engine owns the RAM during WAIT.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (state_q == LOAD) begin
            mem_we   = s_valid;
            mem_addr = in_addr_q + idx_q;
            mem_din  = s_valid ? s_data : '0;
        end else if (state_q == RD) begin
            mem_addr = out_addr_q + idx_q;
        end
    end

    assign s_ready          = (state_q == LOAD);
    assign busy             = (state_q != IDLE);
    assign m_valid          = m_valid_q;
    assign m_data           = m_data_q;
    assign m_last           = m_last_q;
    assign fir_start        = fir_start_q;
    assign job_done         = job_done_q;
    assign err              = err_q;
    assign fir_input_addr   = in_addr_q;
    assign fir_output_addr  = out_addr_q;
    assign fir_sample_count = count_q;

endmodule
